// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared constants and types for the instruction fetch slice.
//   RESET_PC_DEFAULT : default fetch address after reset
//   ILEN             : instruction / address width
//   OP_*, F3_*, F7B5 : bit positions of the decode fields inside a word
//   fetch_entry_t    : one buffered fetch, {pc, instr}, 64 bits packed
//   wordAlign()      : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package rv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          ILEN             = 32;

    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 6;
    localparam int F3_LSB   = 12;
    localparam int F3_MSB   = 14;
    localparam int F7B5_BIT = 30;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Redirect targets may carry garbage in the byte-offset bits; fetch is
    // always word aligned, so those bits are forced to zero.
    function automatic logic [ILEN-1:0] wordAlign(input logic [ILEN-1:0] addr);
        return addr & ~ILEN'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles every handshake/bus signal of the fetch unit.
//   imem request : imem_req_valid, imem_req_ready, imem_addr
//   imem response: imem_rsp_valid, imem_rsp_data (in order, no back-pressure)
//   decode side  : instr_valid, instr_ready, instr, op, funct3, funct7b5,
//                  instr_pc, instr_pcplus4
//   redirect     : redirect_valid, redirect_target
// master = the fetch unit, slave = memory/decode/execute side.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;
    import rv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [ILEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [ILEN-1:0] instr_pc;
    logic [ILEN-1:0] instr_pcplus4;
    logic            redirect_valid;
    logic [ILEN-1:0] redirect_target;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr, op, funct3, funct7b5, instr_pc, instr_pcplus4,
        input  instr_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr, op, funct3, funct7b5, instr_pc, instr_pcplus4,
        output instr_ready, redirect_valid, redirect_target
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched {pc, instr} entries.
//   clk, reset     : clock, synchronous active-high reset
//   push_i/data_i  : write one entry
//   pop_i          : drop the head entry
//   flush_i        : empty the FIFO, overriding any push/pop that cycle
//   head_o         : registered head entry (last contents when empty, never X)
//   count_o        : number of valid entries
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic             doPush;
    logic             doPop;

    // A push into a full FIFO is only legal when the head leaves in the
    // same cycle; the caller's credit scheme normally keeps it from happening.
    assign doPop  = pop_i && (count_q != '0);
    assign doPush = push_i && ((count_q != CW'(DEPTH)) || doPop);

    // Storage is cleared on reset so the head never reads as X; pointers
    // wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
                wrPtr_q        <= wrPtr_q + PW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            count_q <= count_q + CW'(doPush) - CW'(doPop);
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: holds the PC, issues word requests to instruction memory,
// buffers in-order responses and presents them to decode.
//   clk, reset : clock, synchronous active-high reset
//   bus        : instr_fetch_unit_if.master (imem request/response, decode
//                handshake with decoded fields, redirect from execute)
// Parameters: DEPTH (FIFO entries and credit cap), RESET_PC.
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = CW + 2;

    logic [ILEN-1:0]   pcFetch_q, pcFetch_d;
    logic [ILEN-1:0]   rspPc_q, rspPc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     dropCnt_q, dropCnt_d;
    logic [CW-1:0]     fifoCount;
    logic              creditOk;
    logic              reqFire;
    logic              liveRsp;
    logic              dropRsp;
    logic              fifoPop;
    logic [ILEN-1:0]   redirectPc;
    fetch_entry_t      pushEntry;
    fetch_entry_t      headEntry;
    logic [2*ILEN-1:0] headBits;

    // Every request in flight (live or doomed) and every buffered entry holds
    // a credit, so a live response always finds a free FIFO slot.
    assign creditOk = (SW'(outstanding_q) + SW'(fifoCount) + SW'(dropCnt_q)) < SW'(DEPTH);

    assign bus.imem_req_valid = !reset && !bus.redirect_valid && creditOk;
    assign bus.imem_addr      = pcFetch_q;

    assign reqFire    = bus.imem_req_valid && bus.imem_req_ready;
    assign dropRsp    = bus.imem_rsp_valid && (dropCnt_q != '0);
    assign liveRsp    = bus.imem_rsp_valid && (dropCnt_q == '0);
    assign fifoPop    = bus.instr_valid && bus.instr_ready;
    assign redirectPc = wordAlign(bus.redirect_target);

    // Requests are sequential between redirects, so the PC of the next live
    // response is simply tracked instead of queued: it restarts at the
    // redirect target (or RESET_PC) and steps by 4 per live response.
    // On a redirect every in-flight request becomes one to drop; a response
    // arriving in that same cycle is the oldest one and is discounted.
    always_comb begin
        pcFetch_d     = pcFetch_q;
        rspPc_d       = rspPc_q;
        outstanding_d = outstanding_q;
        dropCnt_d     = dropCnt_q;
        if (bus.redirect_valid) begin
            pcFetch_d     = redirectPc;
            rspPc_d       = redirectPc;
            outstanding_d = '0;
            dropCnt_d     = dropCnt_q + outstanding_q - CW'(bus.imem_rsp_valid);
        end else begin
            if (reqFire) begin
                pcFetch_d = pcFetch_q + ILEN'(4);
            end
            if (liveRsp) begin
                rspPc_d = rspPc_q + ILEN'(4);
            end
            outstanding_d = outstanding_q + CW'(reqFire) - CW'(liveRsp);
            if (dropRsp) begin
                dropCnt_d = dropCnt_q - CW'(1);
            end
        end
    end

    // Fetch pointer and credit counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcFetch_q     <= RESET_PC;
            rspPc_q       <= RESET_PC;
            outstanding_q <= '0;
            dropCnt_q     <= '0;
        end else begin
            pcFetch_q     <= pcFetch_d;
            rspPc_q       <= rspPc_d;
            outstanding_q <= outstanding_d;
            dropCnt_q     <= dropCnt_d;
        end
    end

    assign pushEntry = '{pc: rspPc_q, instr: bus.imem_rsp_data};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*ILEN)
    ) u_fetch_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (liveRsp),
        .data_i  (pushEntry),
        .pop_i   (fifoPop),
        .flush_i (bus.redirect_valid),
        .head_o  (headBits),
        .count_o (fifoCount)
    );

    assign headEntry         = fetch_entry_t'(headBits);
    assign bus.instr_valid   = (fifoCount != '0);
    assign bus.instr         = headEntry.instr;
    assign bus.op            = headEntry.instr[OP_MSB:OP_LSB];
    assign bus.funct3        = headEntry.instr[F3_MSB:F3_LSB];
    assign bus.funct7b5      = headEntry.instr[F7B5_BIT];
    assign bus.instr_pc      = headEntry.pc;
    assign bus.instr_pcplus4 = headEntry.pc + ILEN'(4);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Drives instr_fetch_unit with a behavioural in-order memory, directed
// scenarios and a randomized phase; a queue-based model of the fetch stage
// predicts the outputs every cycle.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct { logic [31:0] pc; bit stale; }          flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } slot_t;
    typedef struct { logic [31:0] addr; int due; }          memreq_t;

    logic clk;
    logic reset;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks;
    int failures;
    int cycleCount;
    int lastDue;
    int memLat;
    bit jitter;
    int reqFireCount;
    bit modelValid;

    flight_t     flightQ[$];
    slot_t       fifoQ[$];
    memreq_t     memQ[$];
    logic [31:0] mPc;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory contents: two fixed words at the bottom, a hash elsewhere.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00a0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Holds one cycle of inputs: drives just after the rising edge, returns
    // mid-cycle so callers can sample settled outputs.
    task automatic applyStimulus(input bit rst, input bit redir, input logic [31:0] tgt,
                                 input bit iRdy, input bit mRdy);
        @(posedge clk);
        #1;
        reset               = rst;
        bus.redirect_valid  = redir;
        bus.redirect_target = tgt;
        bus.instr_ready     = iRdy;
        bus.imem_req_ready  = mRdy;
        if (memQ.size() != 0 && memQ[0].due <= cycleCount) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memWord(memQ[0].addr);
            void'(memQ.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        @(negedge clk);
    endtask

    // Redirect somewhere, then let every stale response come back and the
    // buffer drain with no new requests.
    task automatic drainTo(input logic [31:0] tgt);
        applyStimulus(1'b0, 1'b1, tgt, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    // Compare the DUT with the model, then advance the model and the memory
    // by what happens at the coming rising edge.
    always @(negedge clk) begin
        bit          expReq;
        bit          fire;
        logic [31:0] hw;
        logic [31:0] hp;
        flight_t     f;
        int          due;

        expReq = !reset && !bus.redirect_valid && ((flightQ.size() + fifoQ.size()) < DEPTH);

        if (modelValid) begin
            checkOutput("cmp req_valid", 32'(bus.imem_req_valid), 32'(expReq));
            checkOutput("cmp imem_addr", bus.imem_addr, mPc);
            checkOutput("cmp instr_valid", 32'(bus.instr_valid), 32'(fifoQ.size() != 0));
            checkOutput("cmp instr_known", 32'(^bus.instr === 1'bx), 32'h0);
            if (fifoQ.size() != 0) begin
                hw = fifoQ[0].word;
                hp = fifoQ[0].pc;
                checkOutput("cmp instr", bus.instr, hw);
                checkOutput("cmp op", 32'(bus.op), 32'(hw[6:0]));
                checkOutput("cmp funct3", 32'(bus.funct3), 32'(hw[14:12]));
                checkOutput("cmp funct7b5", 32'(bus.funct7b5), 32'(hw[30]));
                checkOutput("cmp instr_pc", bus.instr_pc, hp);
                checkOutput("cmp instr_pcplus4", bus.instr_pcplus4, hp + 32'd4);
            end
        end

        if (reset) begin
            modelValid = 1'b1;
            mPc        = RST_PC;
            flightQ.delete();
            fifoQ.delete();
            memQ.delete();
            lastDue = cycleCount;
        end else begin
            if (modelValid) begin
                fire = expReq && bus.imem_req_ready;
                if (fifoQ.size() != 0 && bus.instr_ready) void'(fifoQ.pop_front());
                if (bus.imem_rsp_valid && flightQ.size() != 0) begin
                    f = flightQ.pop_front();
                    if (!f.stale) fifoQ.push_back('{pc: f.pc, word: bus.imem_rsp_data});
                end
                if (bus.redirect_valid) begin
                    fifoQ.delete();
                    foreach (flightQ[i]) flightQ[i].stale = 1'b1;
                    mPc = bus.redirect_target & ~32'h3;
                end else if (fire) begin
                    flightQ.push_back('{pc: mPc, stale: 1'b0});
                    mPc = mPc + 32'd4;
                end
            end
            if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready) begin
                due = cycleCount + memLat + (jitter ? int'($urandom_range(0, 2)) : 0);
                if (due <= lastDue) due = lastDue + 1;
                lastDue = due;
                memQ.push_back('{addr: bus.imem_addr, due: due});
                reqFireCount++;
            end
        end
        cycleCount++;
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        bit seen;
        int firesBefore;

        checks = 0; failures = 0; cycleCount = 0; lastDue = 0;
        memLat = 1; jitter = 1'b0; reqFireCount = 0; modelValid = 1'b0;
        mPc = RST_PC;
        reset = 1'b1;
        bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0;
        bus.instr_ready = 1'b0; bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("reset req_valid", 32'(bus.imem_req_valid), 32'h0);
        checkOutput("reset instr_valid", 32'(bus.instr_valid), 32'h0);
        #1 firesBefore = reqFireCount;

        // Fetch from reset with decode stalled; credit stops after two.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t1 req_valid c0", 32'(bus.imem_req_valid), 32'h1);
        checkOutput("t1 addr c0", bus.imem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t1 addr c1", bus.imem_addr, 32'h4);
        checkOutput("t1 instr_valid c1", 32'(bus.instr_valid), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t1 instr_valid c2", 32'(bus.instr_valid), 32'h1);
        checkOutput("t1 instr c2", bus.instr, 32'h0050_0093);
        checkOutput("t1 op c2", 32'(bus.op), 32'h13);
        checkOutput("t1 funct3 c2", 32'(bus.funct3), 32'h0);
        checkOutput("t1 instr_pc c2", bus.instr_pc, 32'h0);
        checkOutput("t1 pcplus4 c2", bus.instr_pcplus4, 32'h4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            checkOutput("t2 req_valid stalled", 32'(bus.imem_req_valid), 32'h0);
            checkOutput("t2 head held", bus.instr, 32'h0050_0093);
        end
        #1;
        checkOutput("t2 request count", 32'(reqFireCount - firesBefore), 32'h2);
        checkOutput("t2 model fifo depth", 32'(fifoQ.size()), 32'h2);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t2 second head pc", bus.instr_pc, 32'h4);
        checkOutput("t2 second head", bus.instr, 32'h00a0_0113);
        checkOutput("t2 refill addr", bus.imem_addr, 32'h8);
        checkOutput("t2 refill req", 32'(bus.imem_req_valid), 32'h1);

        // Redirect with two requests in flight.
        drainTo(32'h200);
        memLat = 3;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
        checkOutput("t3 no req on redirect", 32'(bus.imem_req_valid), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t3 addr after redirect", bus.imem_addr, 32'h100);
        checkOutput("t3 empty after redirect", 32'(bus.instr_valid), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            seen = (bus.instr_valid === 1'b1);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL t3 wait actual=no_instr_valid expected=instr_valid");
        end else begin
            checkOutput("t3 first pc", bus.instr_pc, 32'h100);
            checkOutput("t3 first instr", bus.instr, memWord(32'h100));
        end

        // Redirect colliding with a response and a pop.
        memLat = 1;
        drainTo(32'h200);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h103, 1'b1, 1'b1);
        checkOutput("t4 head before redirect", 32'(bus.instr_valid), 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t4 flushed", 32'(bus.instr_valid), 32'h0);
        checkOutput("t4 aligned pc", bus.imem_addr, 32'h100);
        checkOutput("t4 req after redirect", 32'(bus.imem_req_valid), 32'h1);

        // Address wrap at the top of memory.
        drainTo(32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t5 addr top", bus.imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t5 addr wrapped", bus.imem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t5 head pc", bus.instr_pc, 32'hFFFF_FFFC);
        checkOutput("t5 head pcplus4", bus.instr_pcplus4, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t6 full valid", 32'(bus.instr_valid), 32'h1);
        checkOutput("t6 full no req", 32'(bus.imem_req_valid), 32'h0);

        // Reset with a full buffer.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t6 req in reset", 32'(bus.imem_req_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t6 empty after reset", 32'(bus.instr_valid), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("t6 addr after release", bus.imem_addr, RST_PC);
        checkOutput("t6 req after release", 32'(bus.imem_req_valid), 32'h1);

        // Randomized traffic: jittery memory latency, random ready on both
        // sides, occasional redirects and resets.
        jitter = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 24) == 0,
                          $urandom,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0);
        end
        drainTo(32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
